// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU data memory: access-size encoding, FSM states
// and the supported read-latency range.
package lsu_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_ILL = 2'b11;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  function automatic logic size_illegal(input logic [1:0] size);
    return size == SZ_ILL;
  endfunction

endpackage

// File: rtl/lsu_data_mem_if.sv
// Request/response bus between a load/store unit and the data memory.
interface lsu_data_mem_if #(
  parameter int WORD_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load
// extraction with sign/zero extension, and misalignment detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    rbyte     = rword[{addr_lo, 3'b000} +: 8];
    rhalf     = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_B: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{~is_unsigned & rbyte[7]}}, rbyte};
      end
      SZ_H: begin
        misalign  = addr_lo[0];
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{~is_unsigned & rhalf[15]}}, rhalf};
      end
      SZ_W: begin
        misalign  = (addr_lo != 2'b00);
        byte_en   = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_data_mem.sv
// Single-port data memory behind an LSU request/response bus, with a fixed
// programmable read latency and error responses for bad accesses.
//
//   state   | meaning
//   IDLE    | no response pending, ready for a request
//   WAIT    | load accepted, counting down to its response
//   RESP    | response on the bus this cycle, ready for a request
module lsu_data_mem
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int RD_LAT      = 1,
  parameter int WORD_W      = 32
) (
  input logic             clk,
  input logic             rst_n,
  lsu_data_mem_if.slave   bus
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam logic [1:0]  WAIT_INIT  = (LAT > 1) ? 2'(LAT - 2) : 2'd0;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  lsu_state_e        state;
  logic              ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [WORD_W-1:0] rsp_rdata_q;
  logic [WORD_W-1:0] hold_q;
  logic [1:0]        cnt;

  logic [AW-1:0]     idx;
  logic [WORD_W-1:0] rword;
  logic [3:0]        byte_en;
  logic [WORD_W-1:0] wdata_rep;
  logic [WORD_W-1:0] load_ext;
  logic              misalign;
  logic              acc_err;
  logic              accept;
  logic              wr_en;

  assign idx     = bus.req_addr[AW+1:2];
  assign rword   = mem[idx];
  assign accept  = bus.req_valid & ready_q;
  assign acc_err = misalign | size_illegal(bus.req_size) | (bus.req_addr >= ADDR_LIMIT);
  assign wr_en   = accept & bus.req_we & ~acc_err;

  lsu_align u_align (
    .addr_lo     (bus.req_addr[1:0]),
    .size        (bus.req_size),
    .is_unsigned (bus.req_unsigned),
    .wdata       (bus.req_wdata),
    .rword       (rword),
    .byte_en     (byte_en),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (load_ext),
    .misalign    (misalign)
  );

  // Storage is deliberately left out of reset so committed data survives it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      hold_q      <= '0;
      cnt         <= 2'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      ready_q     <= 1'b1;
      case (state)
        ST_WAIT: begin
          if (cnt == 2'd0) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= hold_q;
          end else begin
            cnt     <= cnt - 2'd1;
            ready_q <= 1'b0;
          end
        end
        default: begin
          if (!accept) begin
            state <= ST_IDLE;
          end else if (acc_err) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else if (bus.req_we || LAT == 1) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= bus.req_we ? '0 : load_ext;
          end else begin
            // Data is captured now; no store can slip in while ready is low.
            state   <= ST_WAIT;
            cnt     <= WAIT_INIT;
            hold_q  <= load_ext;
            ready_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_data_mem.sv
// Directed bench: two memories (RD_LAT=1 and RD_LAT=3) share stimulus and are
// checked against hand-computed data, error flags and response latencies.
module tb_lsu_data_mem;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v_f = 1'b0;
  logic        v_s = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0]  size = SZ_W;
  logic        uns = 1'b0;
  logic [31:0] wdata = '0;

  int n_chk = 0;
  int n_err = 0;

  int          f_n, s_n;
  int          f_k [4];
  int          s_k [4];
  logic [31:0] f_d [4];
  logic [31:0] s_d [4];
  logic        f_e [4];
  logic        s_e [4];

  always #5 clk = ~clk;

  lsu_data_mem_if bus_f ();
  lsu_data_mem_if bus_s ();

  assign bus_f.req_valid    = v_f;
  assign bus_s.req_valid    = v_s;
  assign bus_f.req_we       = we;
  assign bus_s.req_we       = we;
  assign bus_f.req_addr     = addr;
  assign bus_s.req_addr     = addr;
  assign bus_f.req_size     = size;
  assign bus_s.req_size     = size;
  assign bus_f.req_unsigned = uns;
  assign bus_s.req_unsigned = uns;
  assign bus_f.req_wdata    = wdata;
  assign bus_s.req_wdata    = wdata;

  lsu_data_mem #(.DEPTH_WORDS(256), .RD_LAT(1), .WORD_W(32)) dut_f (
    .clk (clk), .rst_n (rst_n), .bus (bus_f)
  );
  lsu_data_mem #(.DEPTH_WORDS(256), .RD_LAT(3), .WORD_W(32)) dut_s (
    .clk (clk), .rst_n (rst_n), .bus (bus_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic clr_rec();
    f_n = 0;
    s_n = 0;
    for (int i = 0; i < 4; i++) begin
      f_k[i] = 0; s_k[i] = 0; f_d[i] = '0; s_d[i] = '0; f_e[i] = 1'b0; s_e[i] = 1'b0;
    end
  endtask

  task automatic sample(input int k);
    if (bus_f.rsp_valid) begin
      if (f_n < 4) begin f_k[f_n] = k; f_d[f_n] = bus_f.rsp_rdata; f_e[f_n] = bus_f.rsp_err; end
      f_n++;
    end
    if (bus_s.rsp_valid) begin
      if (s_n < 4) begin s_k[s_n] = k; s_d[s_n] = bus_s.rsp_rdata; s_e[s_n] = bus_s.rsp_err; end
      s_n++;
    end
  endtask

  task automatic do_req(input string tag, input logic w, input logic [31:0] a,
                        input logic [1:0] sz, input logic u, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e,
                        input int lat_f, input int lat_s);
    @(negedge clk);
    we = w; addr = a; size = sz; uns = u; wdata = wd; v_f = 1'b1; v_s = 1'b1;
    chk({tag, "/rdy_f"}, 32'(bus_f.req_ready), 32'd1);
    chk({tag, "/rdy_s"}, 32'(bus_s.req_ready), 32'd1);
    clr_rec();
    @(negedge clk);
    v_f = 1'b0; v_s = 1'b0;
    sample(1);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      sample(k);
    end
    chk({tag, "/n_f"},   32'(f_n),    32'd1);
    chk({tag, "/n_s"},   32'(s_n),    32'd1);
    chk({tag, "/lat_f"}, 32'(f_k[0]), 32'(lat_f));
    chk({tag, "/lat_s"}, 32'(s_k[0]), 32'(lat_s));
    chk({tag, "/d_f"},   f_d[0],      exp_d);
    chk({tag, "/d_s"},   s_d[0],      exp_d);
    chk({tag, "/e_f"},   32'(f_e[0]), 32'(exp_e));
    chk({tag, "/e_s"},   32'(s_e[0]), 32'(exp_e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    int low;

    clr_rec();
    repeat (3) @(negedge clk);
    chk("rst/rdy_f", 32'(bus_f.req_ready), 32'd0);
    chk("rst/rdy_s", 32'(bus_s.req_ready), 32'd0);
    chk("rst/vld_f", 32'(bus_f.rsp_valid), 32'd0);
    chk("rst/vld_s", 32'(bus_s.rsp_valid), 32'd0);
    chk("rst/err_s", 32'(bus_s.rsp_err),   32'd0);
    chk("rst/dat_s", bus_s.rsp_rdata,      32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel/rdy_f", 32'(bus_f.req_ready), 32'd1);
    chk("rel/rdy_s", 32'(bus_s.req_ready), 32'd1);

    do_req("st_w10",  1'b1, 32'h10,  SZ_W, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 1, 1);
    do_req("ld_w10",  1'b0, 32'h10,  SZ_W, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 1, 3);
    do_req("st_b13",  1'b1, 32'h13,  SZ_B, 1'b0, 32'hAAAAAA80, 32'h0,        1'b0, 1, 1);
    do_req("ld_sb13", 1'b0, 32'h13,  SZ_B, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, 1, 3);
    do_req("ld_ub13", 1'b0, 32'h13,  SZ_B, 1'b1, 32'h0,        32'h00000080, 1'b0, 1, 3);
    do_req("ld_w10b", 1'b0, 32'h10,  SZ_W, 1'b0, 32'h0,        32'h80ADBEEF, 1'b0, 1, 3);
    do_req("st_h11",  1'b1, 32'h11,  SZ_H, 1'b0, 32'h00001111, 32'h0,        1'b1, 1, 1);
    do_req("ld_w22",  1'b0, 32'h22,  SZ_W, 1'b0, 32'h0,        32'h0,        1'b1, 1, 1);
    do_req("ld_w10c", 1'b0, 32'h10,  SZ_W, 1'b0, 32'h0,        32'h80ADBEEF, 1'b0, 1, 3);
    do_req("ld_oor",  1'b0, 32'h400, SZ_W, 1'b0, 32'h0,        32'h0,        1'b1, 1, 1);
    do_req("st_oor",  1'b1, 32'h410, SZ_W, 1'b0, 32'h12345678, 32'h0,        1'b1, 1, 1);
    do_req("ld_ill",  1'b0, 32'h10,  SZ_ILL, 1'b0, 32'h0,      32'h0,        1'b1, 1, 1);
    do_req("st_ill",  1'b1, 32'h10,  SZ_ILL, 1'b0, 32'h0,      32'h0,        1'b1, 1, 1);
    do_req("ld_w10d", 1'b0, 32'h10,  SZ_W, 1'b0, 32'h0,        32'h80ADBEEF, 1'b0, 1, 3);
    do_req("ld_sb10", 1'b0, 32'h10,  SZ_B, 1'b0, 32'h0,        32'hFFFFFFEF, 1'b0, 1, 3);
    do_req("ld_ub11", 1'b0, 32'h11,  SZ_B, 1'b1, 32'h0,        32'h000000BE, 1'b0, 1, 3);
    do_req("ld_sh12", 1'b0, 32'h12,  SZ_H, 1'b0, 32'h0,        32'hFFFF80AD, 1'b0, 1, 3);
    do_req("st_h16",  1'b1, 32'h16,  SZ_H, 1'b0, 32'hFFFF1234, 32'h0,        1'b0, 1, 1);
    do_req("st_h14",  1'b1, 32'h14,  SZ_H, 1'b0, 32'h00008001, 32'h0,        1'b0, 1, 1);
    do_req("ld_sh14", 1'b0, 32'h14,  SZ_H, 1'b0, 32'h0,        32'hFFFF8001, 1'b0, 1, 3);
    do_req("ld_uh14", 1'b0, 32'h14,  SZ_H, 1'b1, 32'h0,        32'h00008001, 1'b0, 1, 3);
    do_req("ld_sh16", 1'b0, 32'h16,  SZ_H, 1'b0, 32'h0,        32'h00001234, 1'b0, 1, 3);
    do_req("ld_w14",  1'b0, 32'h14,  SZ_W, 1'b0, 32'h0,        32'h12348001, 1'b0, 1, 3);
    do_req("st_top",  1'b1, 32'h3FC, SZ_W, 1'b0, 32'h01020304, 32'h0,        1'b0, 1, 1);
    do_req("ld_top",  1'b0, 32'h3FC, SZ_W, 1'b0, 32'h0,        32'h01020304, 1'b0, 1, 3);
    do_req("ld_ub3f", 1'b0, 32'h3FF, SZ_B, 1'b1, 32'h0,        32'h00000001, 1'b0, 1, 3);

    // Store then load of the same word on consecutive edges.
    @(negedge clk);
    we = 1'b1; addr = 32'h30; size = SZ_W; uns = 1'b0; wdata = 32'hCAFEF00D;
    v_f = 1'b1; v_s = 1'b1;
    clr_rec();
    @(negedge clk);
    sample(1);
    chk("b2b/rdy_f", 32'(bus_f.req_ready), 32'd1);
    chk("b2b/rdy_s", 32'(bus_s.req_ready), 32'd1);
    we = 1'b0;
    @(negedge clk);
    sample(2);
    v_f = 1'b0; v_s = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      sample(k);
    end
    chk("b2b/n_f",   32'(f_n),    32'd2);
    chk("b2b/n_s",   32'(s_n),    32'd2);
    chk("b2b/k0_f",  32'(f_k[0]), 32'd1);
    chk("b2b/k1_f",  32'(f_k[1]), 32'd2);
    chk("b2b/k1_s",  32'(s_k[1]), 32'd4);
    chk("b2b/d0_f",  f_d[0],      32'h0);
    chk("b2b/d1_f",  f_d[1],      32'hCAFEF00D);
    chk("b2b/d1_s",  s_d[1],      32'hCAFEF00D);

    for (int i = 0; i < 4; i++) begin
      do_req("st_burst", 1'b1, 32'h20 + 32'(4*i), SZ_W, 1'b0, 32'hA5000020 + 32'(4*i),
             32'h0, 1'b0, 1, 1);
    end

    // Four loads with valid held continuously on the RD_LAT=3 memory only.
    clr_rec();
    n_acc = 0;
    low = 0;
    @(negedge clk);
    we = 1'b0; size = SZ_W; uns = 1'b0; addr = 32'h20; v_s = 1'b1;
    if (bus_s.req_ready) n_acc = 1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      sample(cyc);
      if (!bus_s.req_ready) low++;
      if (n_acc < 4) begin
        addr = 32'h20 + 32'(4*n_acc);
        if (bus_s.req_ready) n_acc++;
      end else begin
        v_s = 1'b0;
      end
    end
    v_s = 1'b0;
    chk("burst/n_s",  32'(s_n), 32'd4);
    chk("burst/n_f",  32'(f_n), 32'd0);
    chk("burst/low",  32'(low), 32'd8);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("burst/k%0d", i), 32'(s_k[i]), 32'(3 + 3*i));
      chk($sformatf("burst/d%0d", i), s_d[i],      32'hA5000020 + 32'(4*i));
    end

    // Reset while a RD_LAT=3 load sits in WAIT.
    @(negedge clk);
    we = 1'b0; addr = 32'h10; size = SZ_W; uns = 1'b0; v_s = 1'b1;
    @(negedge clk);
    v_s = 1'b0;
    chk("mid/wait_rdy", 32'(bus_s.req_ready), 32'd0);
    #2 rst_n = 1'b0;
    clr_rec();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      sample(k);
    end
    chk("mid/rst_rdy_s", 32'(bus_s.req_ready), 32'd0);
    chk("mid/rst_rdy_f", 32'(bus_f.req_ready), 32'd0);
    chk("mid/rst_dat_s", bus_s.rsp_rdata,      32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    sample(5);
    chk("mid/rel_rdy_s", 32'(bus_s.req_ready), 32'd1);
    for (int k = 6; k <= 9; k++) begin
      @(negedge clk);
      sample(k);
    end
    chk("mid/no_rsp_s", 32'(s_n), 32'd0);
    chk("mid/no_rsp_f", 32'(f_n), 32'd0);
    do_req("post_w10", 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0, 1, 3);
    do_req("post_w30", 1'b0, 32'h30, SZ_W, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 1, 3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_data_mem.md
LSU_DATA_MEM -- requirements
Module: lsu_data_mem

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words stored; power of two, 16..4096.
REQ-002 Parameter RD_LAT, default 1: read latency in cycles from request acceptance to response; range 1..4.
REQ-003 Parameter WORD_W, default 32: data word width; fixed at 32 for this generation.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port req_valid, input, 1: request present.
REQ-007 Port req_ready, output, 1: block accepts a request this cycle.
REQ-008 Port req_we, input, 1: 1 = store, 0 = load.
REQ-009 Port req_addr, input, 32: byte address.
REQ-010 Port req_size, input, 2: access size; 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-011 Port req_unsigned, input, 1: load zero-extends when 1 and sign-extends when 0.
REQ-012 Port req_wdata, input, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 Port rsp_valid, output, 1: one-cycle response pulse.
REQ-014 Port rsp_rdata, output, 32: load result, extended to 32 bits; 0 for stores and errors.
REQ-015 Port rsp_err, output, 1: misaligned, out-of-range or illegal-size access; qualified by rsp_valid.

Function
REQ-016 A request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-017 The control FSM has three states: IDLE, WAIT and RESP.
REQ-018 FSM transitions:
- IDLE -> RESP on a store, an errored access, or a load with RD_LAT=1.
- IDLE -> WAIT on a load with RD_LAT>1; stay in WAIT for RD_LAT-1 cycles, then go to RESP.
- RESP -> IDLE when no new request is accepted.
- RESP -> RESP or WAIT when a new request is accepted, following the IDLE rules.
REQ-019 req_ready SHALL be 1 in IDLE and RESP and 0 in WAIT.
REQ-020 rsp_valid SHALL be 1 exactly in RESP, one cycle per accepted request, with no backpressure.
REQ-021 Load response timing: rsp_valid is asserted RD_LAT cycles after the acceptance edge.
REQ-022 Store response timing: rsp_valid is asserted in the cycle after the acceptance edge, whatever RD_LAT is.
REQ-023 Stores commit on the acceptance edge using byte-lane enables derived from req_addr[1:0] and req_size; only the addressed lanes change.
REQ-024 Loads select the addressed byte or half from the word and then extend it according to req_unsigned.
REQ-025 The word index is req_addr[log2(DEPTH_WORDS)+1:2].
REQ-026 Misaligned accesses are errors: half with req_addr[0]=1, or word with req_addr[1:0]!=0.
REQ-027 Out-of-range accesses are errors: any req_addr >= 4*DEPTH_WORDS.
REQ-028 req_size=11 is an error.
REQ-029 An errored access SHALL NOT write memory and SHALL respond after 1 cycle with rsp_err=1 and rsp_rdata=0.
REQ-030 A load accepted on the edge after a store to the same word SHALL return the new data.
REQ-031 Back-to-back requests accepted in RESP SHALL respond in order, with no cycle lost for stores or for RD_LAT=1 loads.

Reset
REQ-032 While rst_n=0: FSM is in IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, and the WAIT counter is 0.
REQ-033 req_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-034 Reset asserted mid-operation discards any in-flight load, and no response is issued for it.
REQ-035 Memory contents are not reset; stores already committed before reset remain.

Structure
REQ-036 Shared package lsu_pkg holds:
- the size encoding constants (SZ_B, SZ_H, SZ_W);
- the FSM state enum;
- the RD_LAT legal-range constants.
REQ-037 A combinational sub-module lsu_align generates the byte-lane enables, the store data replication, the load extraction and extension, and the misalignment detection.
REQ-038 The storage array is inferred from DEPTH_WORDS and uses a single read/write port.

Verification
REQ-039 Scenario: store word 0xDEADBEEF to address 0x10, then load word from 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, with the response RD_LAT cycles after acceptance.
REQ-040 Scenario: store byte 0x80 to address 0x13, then signed byte load from 0x13 -> 0xFFFFFF80; unsigned byte load -> 0x00000080; word load from 0x10 -> 0x80ADBEEF.
REQ-041 Scenario: half store to address 0x11, then word load from 0x22 -> each returns rsp_err=1 after 1 cycle, and memory is unchanged.
REQ-042 Scenario: with DEPTH_WORDS=256, load from 0x400 -> rsp_err=1 and rsp_rdata=0.
REQ-043 Scenario: with RD_LAT=3, present continuous req_valid with 4 loads -> req_ready low for 2 cycles per load, and 4 in-order rsp_valid pulses.
REQ-044 Scenario: pull rst_n low in the WAIT state of a RD_LAT=3 load -> no rsp_valid is issued, and the data stored before reset is still readable afterwards.
